// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and types for the data-memory arbiter.
package dmem_arbiter_pkg;

   // Access size encodings on req_size
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   // Transaction FSM states
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] WRITE  = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   // Control fields latched from the granted requester
   typedef struct packed {
      logic       we;
      logic [1:0] size;
      logic       uns;
      logic [1:0] lane;
   } req_ctrl_t;

endpackage

// File: rtl/dmem_arbiter_lane_align.sv
// Byte-lane logic: load extraction/extension, sub-word store merge, alignment check.
module dmem_arbiter_lane_align
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [1:0]            size,
   input  logic [1:0]            lane,
   input  logic                  uns,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] load_data_c,
   output logic [DATA_WIDTH-1:0] merge_data_c,
   output logic                  err_c
);

   localparam int unsigned SHW = $clog2(DATA_WIDTH);

   logic [SHW-1:0]        shamt;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] byte_mask;
   logic [DATA_WIDTH-1:0] half_mask;

   assign shamt     = SHW'({lane, 3'b000});
   assign shifted   = mem_rdata >> shamt;
   assign byte_mask = DATA_WIDTH'(8'hFF) << shamt;
   assign half_mask = DATA_WIDTH'(16'hFFFF) << shamt;

   // Illegal size or misaligned half/word
   always_comb begin
      err_c = (size == SIZE_X) ||
              ((size == SIZE_H) && lane[0]) ||
              ((size == SIZE_W) && (lane != 2'b00));
   end

   // Load path: pick the lane and sign/zero extend
   always_comb begin
      load_data_c = '0;
      case (size)
         SIZE_B:  load_data_c = {{(DATA_WIDTH-8){shifted[7] & ~uns}}, shifted[7:0]};
         SIZE_H:  load_data_c = {{(DATA_WIDTH-16){shifted[15] & ~uns}}, shifted[15:0]};
         SIZE_W:  load_data_c = mem_rdata;
         default: load_data_c = '0;
      endcase
   end

   // Store path: merge right-aligned store data into the current word
   always_comb begin
      merge_data_c = wdata;
      case (size)
         SIZE_B:  merge_data_c = (mem_rdata & ~byte_mask) |
                                 ((wdata & DATA_WIDTH'(8'hFF)) << shamt);
         SIZE_H:  merge_data_c = (mem_rdata & ~half_mask) |
                                 ((wdata & DATA_WIDTH'(16'hFFFF)) << shamt);
         default: merge_data_c = wdata;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word data memory.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned MEM_ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [1:0]                req_we,
   input  logic [3:0]                req_size,
   input  logic [1:0]                req_unsigned,
   input  logic [2*ADDR_WIDTH-1:0]   req_addr,
   input  logic [2*DATA_WIDTH-1:0]   req_wdata,
   output logic [1:0]                rsp_valid,
   output logic                      rsp_err,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH-1:0]     mem_rdata
);

   logic [1:0]                state_q, state_n;
   logic                      last_grant_q, last_grant_n;
   logic                      grant_q, grant_n;
   req_ctrl_t                 ctrl_q, ctrl_n;
   logic [MEM_ADDR_WIDTH-1:0] waddr_q, waddr_n;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_n;
   logic [DATA_WIDTH-1:0]     merge_q, merge_n;
   logic [1:0]                rsp_valid_n;
   logic                      rsp_err_n;
   logic [DATA_WIDTH-1:0]     rsp_rdata_n;

   logic                      sel_c;
   logic [ADDR_WIDTH-1:0]     sel_addr_c;
   logic [DATA_WIDTH-1:0]     load_data_c;
   logic [DATA_WIDTH-1:0]     merge_data_c;
   logic                      err_c;
   logic                      unused_addr_bits;

   // Lane logic always works on the latched request and the current memory word
   dmem_arbiter_lane_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lane_align (
      .size         (ctrl_q.size),
      .lane         (ctrl_q.lane),
      .uns          (ctrl_q.uns),
      .mem_rdata    (mem_rdata),
      .wdata        (wdata_q),
      .load_data_c  (load_data_c),
      .merge_data_c (merge_data_c),
      .err_c        (err_c)
   );

   assign sel_addr_c       = req_addr[sel_c*ADDR_WIDTH +: ADDR_WIDTH];
   assign unused_addr_bits = ^sel_addr_c[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
   assign mem_addr         = waddr_q;
   assign mem_wdata        = (state_q == WRITE) ? merge_q : wdata_q;

   // Round-robin pick: on contention the port not granted last time wins
   always_comb begin
      sel_c = ~req_valid[0];
      if (req_valid == 2'b11) begin
         sel_c = ~last_grant_q;
      end
   end

   // Next-state and memory/handshake decode
   always_comb begin
      state_n      = state_q;
      last_grant_n = last_grant_q;
      grant_n      = grant_q;
      ctrl_n       = ctrl_q;
      waddr_n      = waddr_q;
      wdata_n      = wdata_q;
      merge_n      = merge_q;
      rsp_valid_n  = '0;
      rsp_err_n    = rsp_err;
      rsp_rdata_n  = rsp_rdata;
      req_ready    = '0;
      mem_we       = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready    = 2'b01 << sel_c;
               grant_n      = sel_c;
               last_grant_n = sel_c;
               ctrl_n.we    = req_we[sel_c];
               ctrl_n.size  = req_size[2*sel_c +: 2];
               ctrl_n.uns   = req_unsigned[sel_c];
               ctrl_n.lane  = sel_addr_c[1:0];
               waddr_n      = sel_addr_c[MEM_ADDR_WIDTH+1:2];
               wdata_n      = req_wdata[sel_c*DATA_WIDTH +: DATA_WIDTH];
               state_n      = ACCESS;
            end
         end
         ACCESS: begin
            rsp_err_n   = 1'b0;
            rsp_rdata_n = '0;
            if (err_c) begin
               rsp_err_n   = 1'b1;
               rsp_valid_n = 2'b01 << grant_q;
               state_n     = RESP;
            end else if (!ctrl_q.we) begin
               rsp_rdata_n = load_data_c;
               rsp_valid_n = 2'b01 << grant_q;
               state_n     = RESP;
            end else if (ctrl_q.size == SIZE_W) begin
               mem_we      = 1'b1;
               rsp_valid_n = 2'b01 << grant_q;
               state_n     = RESP;
            end else begin
               merge_n = merge_data_c;
               state_n = WRITE;
            end
         end
         WRITE: begin
            mem_we      = 1'b1;
            rsp_valid_n = 2'b01 << grant_q;
            state_n     = RESP;
         end
         RESP: begin
            rsp_err_n   = 1'b0;
            rsp_rdata_n = '0;
            state_n     = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // A reset cycle must neither accept nor write
      if (rst) begin
         req_ready = '0;
         mem_we    = 1'b0;
      end
   end

   // State and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         ctrl_q       <= '0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         merge_q      <= '0;
         rsp_valid    <= '0;
         rsp_err      <= 1'b0;
         rsp_rdata    <= '0;
      end else begin
         state_q      <= state_n;
         last_grant_q <= last_grant_n;
         grant_q      <= grant_n;
         ctrl_q       <= ctrl_n;
         waddr_q      <= waddr_n;
         wdata_q      <= wdata_n;
         merge_q      <= merge_n;
         rsp_valid    <= rsp_valid_n;
         rsp_err      <= rsp_err_n;
         rsp_rdata    <= rsp_rdata_n;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a scoreboard of expected responses.
module tb_dmem_arbiter;

   localparam int unsigned AW  = 32;
   localparam int unsigned MAW = 10;
   localparam int unsigned DW  = 32;

   localparam logic [1:0] SB = 2'b00;
   localparam logic [1:0] SH = 2'b01;
   localparam logic [1:0] SW = 2'b10;
   localparam logic [1:0] SX = 2'b11;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_valid, req_ready, req_we, req_unsigned, rsp_valid;
   logic [3:0]    req_size;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic          rsp_err;
   logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
   logic          mem_we;
   logic [MAW-1:0] mem_addr;

   logic [DW-1:0]  mem [0:(1<<MAW)-1];
   logic           pl_we;
   logic [MAW-1:0] pl_addr;
   logic [DW-1:0]  pl_data;

   typedef struct packed {
      logic [1:0]  vld;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_WIDTH     (AW),
      .MEM_ADDR_WIDTH (MAW),
      .DATA_WIDTH     (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .rsp_rdata    (rsp_rdata),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   // Memory model: combinational read, clocked write, plus a bench preload port
   always @(posedge clk) begin
      if (mem_we)     mem[mem_addr] <= mem_wdata;
      else if (pl_we) mem[pl_addr]  <= pl_data;
   end
   assign mem_rdata = mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      pl_we   = 1'b1;
      pl_addr = MAW'(idx);
      pl_data = d;
      @(posedge clk); #1;
      pl_we   = 1'b0;
   endtask

   task automatic drive(input int p, input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
      req_we[p]             = we;
      req_size[2*p +: 2]    = sz;
      req_unsigned[p]       = u;
      req_addr[p*AW +: AW]  = a;
      req_wdata[p*DW +: DW] = d;
      req_valid[p]          = 1'b1;
   endtask

   task automatic wait_accept(output logic [1:0] rdy);
      rdy = 2'b00;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            rdy = req_ready;
            break;
         end
      end
   endtask

   // Called just after the accept edge; lat counts that edge as 1
   task automatic wait_rsp(output int lat, output int wr);
      lat = 1;
      wr  = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_we) wr++;
         if (rsp_valid != 2'b00) break;
         @(posedge clk);
         lat++;
      end
   endtask

   task automatic txn(input int p, input logic we, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic e_err, input logic [31:0] e_rd, input int e_lat,
                      input int e_wr, input string tag);
      logic [1:0] rdy;
      logic [1:0] oh;
      int         lat, wr;
      exp_t       ex;
      oh = 2'(1 << p);
      drive(p, we, sz, u, a, d);
      wait_accept(rdy);
      chk({tag, "_ready"}, 32'(rdy), 32'(oh));
      sb.push_back('{vld: oh, err: e_err, rdata: e_rd});
      @(posedge clk); #1;
      req_valid[p] = 1'b0;
      wait_rsp(lat, wr);
      ex = sb.pop_front();
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(ex.vld));
      chk({tag, "_rsp_err"},   32'(rsp_err),   32'(ex.err));
      chk({tag, "_rsp_rdata"}, rsp_rdata,      ex.rdata);
      chk({tag, "_latency"},   32'(lat),       32'(e_lat));
      chk({tag, "_mem_we_cyc"}, 32'(wr),       32'(e_wr));
      @(posedge clk); #1;
      chk({tag, "_pulse_end"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic [1:0] rdy;
      logic [1:0] oh;
      int         lat, wr, exp_port;
      exp_t       ex;

      rst          = 1'b1;
      req_valid    = '0;
      req_we       = '0;
      req_size     = '0;
      req_unsigned = '0;
      req_addr     = '0;
      req_wdata    = '0;
      pl_we        = 1'b0;
      pl_addr      = '0;
      pl_data      = '0;

      preload(0, 32'h80FF_1234);
      preload(1, 32'hCAFE_F00D);
      @(negedge clk);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_ready",  32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Idle cycle after reset
      @(negedge clk);
      chk("idle_ready",     32'(req_ready), 32'd0);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_rsp_err",   32'(rsp_err),   32'd0);
      chk("idle_rsp_rdata", rsp_rdata,      32'd0);
      chk("idle_mem_we",    32'(mem_we),    32'd0);
      @(posedge clk); #1;

      // Loads with extension
      txn(0, 1'b0, SB, 1'b0, 32'h3, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 0, "lb");
      txn(0, 1'b0, SB, 1'b1, 32'h3, 32'h0, 1'b0, 32'h0000_0080, 2, 0, "lbu");
      txn(1, 1'b0, SH, 1'b0, 32'h2, 32'h0, 1'b0, 32'hFFFF_80FF, 2, 0, "lh");

      // Sub-word store via read-modify-write
      preload(0, 32'h1122_3344);
      txn(1, 1'b1, SH, 1'b0, 32'h2, 32'h0000_BEEF, 1'b0, 32'h0, 3, 1, "sh");
      chk("sh_mem", mem[0], 32'hBEEF_3344);

      // Misaligned word load and illegal-size store
      txn(0, 1'b0, SW, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0, 2, 0, "lw_mis");
      chk("lw_mis_mem", mem[1], 32'hCAFE_F00D);
      txn(1, 1'b1, SX, 1'b0, 32'h4, 32'h1234_5678, 1'b1, 32'h0, 2, 0, "sx_ill");
      chk("sx_ill_mem", mem[1], 32'hCAFE_F00D);

      // Word store with high address bits ignored, read back, then byte merge
      txn(0, 1'b1, SW, 1'b0, 32'h0000_1008, 32'hA5A5_5A5A, 1'b0, 32'h0, 2, 1, "sw_hi");
      chk("sw_hi_mem", mem[2], 32'hA5A5_5A5A);
      txn(1, 1'b0, SW, 1'b0, 32'h8, 32'h0, 1'b0, 32'hA5A5_5A5A, 2, 0, "lw");
      txn(0, 1'b1, SB, 1'b0, 32'h9, 32'h0000_007E, 1'b0, 32'h0, 3, 1, "sb");
      chk("sb_mem", mem[2], 32'hA5A5_7E5A);
      txn(1, 1'b0, SB, 1'b1, 32'h9, 32'h0, 1'b0, 32'h0000_007E, 2, 0, "lbu_rb");

      // Reset in the ACCESS cycle of a byte store drops it
      preload(3, 32'h1111_1111);
      drive(0, 1'b1, SB, 1'b0, 32'hC, 32'h0000_00FF);
      wait_accept(rdy);
      chk("rstmid_ready", 32'(rdy), 32'd1);
      @(posedge clk); #1;
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_mem_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid_rsp_err",   32'(rsp_err),   32'd0);
      chk("rstmid_rsp_rdata", rsp_rdata,      32'd0);
      chk("rstmid_mem_we2",   32'(mem_we),    32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rstmid_mem", mem[3], 32'h1111_1111);

      // Contended loads: grants alternate starting with port 0
      preload(4, 32'h4444_0000);
      preload(5, 32'h5555_0001);
      drive(0, 1'b0, SW, 1'b0, 32'h10, 32'h0);
      drive(1, 1'b0, SW, 1'b0, 32'h14, 32'h0);
      exp_port = 0;
      for (int n = 0; n < 6; n++) begin
         oh = 2'(1 << exp_port);
         wait_accept(rdy);
         chk("rr_grant", 32'(rdy), 32'(oh));
         sb.push_back('{vld: oh, err: 1'b0,
                        rdata: (exp_port == 1) ? 32'h5555_0001 : 32'h4444_0000});
         @(posedge clk); #1;
         if (n == 5) req_valid = '0;
         wait_rsp(lat, wr);
         ex = sb.pop_front();
         chk("rr_rsp_valid", 32'(rsp_valid), 32'(ex.vld));
         chk("rr_rsp_rdata", rsp_rdata,      ex.rdata);
         chk("rr_latency",   32'(lat),       32'd2);
         exp_port = 1 - exp_port;
      end
      chk("rr_sb_empty", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("final_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("final_ready",     32'(req_ready), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
